// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked unsigned ALU. Single-cycle ops plus an iterative
//               restoring divider, with zero / carry / divide-by-zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [2:0]           opcode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 flag_zero,
   output logic                 flag_carry,
   output logic                 flag_dz
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_rem;
   logic [WIDTH-1:0]    r_quo;
   logic [WIDTH-1:0]    r_b;
   logic [CW-1:0]       r_cnt;

   logic [2*WIDTH-1:0]  w_ea;
   logic [2*WIDTH-1:0]  w_eb;
   logic [2*WIDTH-1:0]  w_res;
   logic                w_carry;
   logic [WIDTH:0]      w_shift;
   logic [WIDTH:0]      w_trial;
   logic                w_ge;
   logic [WIDTH-1:0]    w_rem_nxt;
   logic [WIDTH-1:0]    w_quo_nxt;
   logic [2*WIDTH-1:0]  w_div_res;

   // Reset overrides the state-derived handshakes immediately.
   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE) && !rst;

   assign w_ea = {{WIDTH{1'b0}}, a};
   assign w_eb = {{WIDTH{1'b0}}, b};

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      case (opcode)
         OP_ADD: begin
            w_res   = w_ea + w_eb;
            w_carry = w_res[WIDTH];
         end
         OP_SUB: begin
            w_res   = w_ea - w_eb;
            w_carry = (a < b);
         end
         OP_MUL:  w_res = w_ea * w_eb;
         OP_DIV:  w_res = '1;
         OP_AND:  w_res = w_ea & w_eb;
         OP_OR:   w_res = w_ea | w_eb;
         OP_XOR:  w_res = w_ea ^ w_eb;
         OP_NOT:  w_res = {{WIDTH{1'b0}}, ~a};
         default: w_res = '0;
      endcase
   end

   // One restoring step: shift the next dividend bit into the partial
   // remainder and keep the subtraction only if it did not go negative.
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_trial   = w_shift - {1'b0, r_b};
   assign w_ge      = ~w_trial[WIDTH];
   assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
   assign w_div_res = {w_rem_nxt, w_quo_nxt};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rem      <= '0;
         r_quo      <= '0;
         r_b        <= '0;
         r_cnt      <= '0;
         result     <= '0;
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
         flag_dz    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_quo <= a;
                  r_b   <= b;
                  r_rem <= '0;
                  r_cnt <= '0;
                  if (opcode == OP_DIV && b != '0) begin
                     r_state <= S_DIV;
                  end else begin
                     result     <= w_res;
                     flag_zero  <= (w_res == '0);
                     flag_carry <= w_carry;
                     flag_dz    <= (opcode == OP_DIV);
                     r_state    <= S_DONE;
                  end
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  result     <= w_div_res;
                  flag_zero  <= (w_div_res == '0);
                  flag_carry <= 1'b0;
                  flag_dz    <= 1'b0;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed vector table plus stall and mid-division reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [2:0]  opcode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        flag_zero;
   logic        flag_carry;
   logic        flag_dz;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .opcode     (opcode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_dz    (flag_dz)
   );

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic        z;
      logic        c;
      logic        d;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] ta,
                         input logic [7:0] tb, input logic [15:0] er, input logic ez,
                         input logic ec, input logic ed, input int el);
      int lat;
      int busy_ready;
      @(negedge clk);
      a = ta; b = tb; opcode = op; in_valid = 1'b1; out_ready = 1'b0;
      check({name, " ready_before"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      busy_ready = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ready++;
         @(posedge clk); #1;
         lat++;
      end
      check({name, " latency"},    32'(lat),        32'(el));
      check({name, " ready_busy"}, 32'(busy_ready), 32'd0);
      check({name, " result"},     32'(result),     32'(er));
      check({name, " zero"},       32'(flag_zero),  32'(ez));
      check({name, " carry"},      32'(flag_carry), 32'(ec));
      check({name, " dz"},         32'(flag_dz),    32'(ed));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " ready_after"}, 32'(in_ready),  32'd1);
      check({name, " valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic seen;

      //           op    a       b       result      z     c     d     lat
      vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b1, 1'b0, 1};
      vecs[1]  = '{3'd0, 8'd0,   8'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[2]  = '{3'd1, 8'd5,   8'd7,   16'hFFFE, 1'b0, 1'b1, 1'b0, 1};
      vecs[3]  = '{3'd1, 8'd7,   8'd7,   16'h0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[4]  = '{3'd1, 8'd10,  8'd3,   16'h0007, 1'b0, 1'b0, 1'b0, 1};
      vecs[5]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 1'b0, 1};
      vecs[6]  = '{3'd2, 8'd0,   8'd5,   16'h0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[7]  = '{3'd3, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0, 9};
      vecs[8]  = '{3'd3, 8'd9,   8'd0,   16'hFFFF, 1'b0, 1'b0, 1'b1, 1};
      vecs[9]  = '{3'd3, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 1'b0, 9};
      vecs[10] = '{3'd3, 8'd3,   8'd10,  16'h0300, 1'b0, 1'b0, 1'b0, 9};
      vecs[11] = '{3'd3, 8'd0,   8'd5,   16'h0000, 1'b1, 1'b0, 1'b0, 9};
      vecs[12] = '{3'd4, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 1'b0, 1};
      vecs[13] = '{3'd5, 8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0, 1'b0, 1};
      vecs[14] = '{3'd6, 8'hAA,  8'hAA,  16'h0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[15] = '{3'd7, 8'h0F,  8'h55,  16'h00F0, 1'b0, 1'b0, 1'b0, 1};
      vecs[16] = '{3'd7, 8'hFF,  8'h00,  16'h0000, 1'b1, 1'b0, 1'b0, 1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; opcode = '0;

      // Reset state
      @(negedge clk);
      check("rst in_ready",  32'(in_ready),  32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst result", 32'(result), 32'd0);
      check("rst flags",  32'({flag_zero, flag_carry, flag_dz}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rel in_ready", 32'(in_ready), 32'd1);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].d, vecs[i].lat);

      // Output stall with a competing request
      @(negedge clk);
      a = 8'd255; b = 8'd255; opcode = 3'd2; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      check("stall valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      a = 8'd1; b = 8'd1; opcode = 3'd0; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d result", k), 32'(result), 32'hFE01);
         check($sformatf("stall%0d hs", k), 32'({out_valid, in_ready}), 32'b10);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("stall handshake", 32'({out_valid, in_ready}), 32'b01);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall next valid",  32'(out_valid), 32'd1);
      check("stall next result", 32'(result),    32'h0002);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of a division
      @(negedge clk);
      a = 8'd200; b = 8'd7; opcode = 3'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("divrst busy", 32'({out_valid, in_ready}), 32'b00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("divrst during", 32'({out_valid, in_ready}), 32'b00);
      repeat (3) @(posedge clk);
      #1;
      check("divrst result", 32'(result), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("divrst ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("divrst no valid", 32'(seen), 32'd0);
      run_op("post_rst add", 3'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 1'b0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
